caliptra_prim_debounce_edge_detector: RTL and testbench
=======================================================

CALIPTRA_PRIM_DEBOUNCE_EDGE_DETECTOR -- requirements
Module: caliptra_prim_debounce_edge_detector

Interface
REQ-001 The block SHALL have parameter Width, default 4, giving the number of independent input channels.
REQ-002 The block SHALL have parameter CntWidth, default 8, giving the width of the per-channel debounce counter and threshold.
REQ-003 The block SHALL have parameter ResetValue [Width-1:0], default '0, giving the reset level of the sync and filtered state.
REQ-004 The block SHALL have parameter EnSync, default 1: 1 inserts a 2-flop synchronizer per channel, 0 uses d_i directly (d_i assumed glitch-free and registered).
REQ-005 The block SHALL have port clk_i, input, 1, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port d_i, input, Width, the raw channel inputs.
REQ-008 The block SHALL have port en_i, input, Width, the per-channel filter enable.
REQ-009 The block SHALL have port debounce_i, input, CntWidth, the shared stability threshold N.
REQ-010 The block SHALL have port mode_i, input, 2*Width, the per-channel event select: bits [2i+1:2i] = 00 none, 01 rise, 10 fall, 11 both.
REQ-011 The block SHALL have port event_clr_i, input, Width, the per-channel sticky event clear.
REQ-012 The block SHALL have port q_filt_o, output, Width, the debounced level.
REQ-013 The block SHALL have ports q_posedge_pulse_o and q_negedge_pulse_o, output, Width each, one-cycle edge pulses of q_filt_o.
REQ-014 The block SHALL have port event_o, output, Width, the sticky mode-qualified events.
REQ-015 The block SHALL have port irq_o, output, 1, equal to the OR of event_o.

Function
REQ-016 Sync stage: a d_i change SHALL be visible as synced value s after 2 clk_i edges when EnSync=1, and after 0 edges (combinational) when EnSync=0.
REQ-017 Per channel, with en_i=1 and s != q_filt_o: if cnt >= debounce_i, q_filt_o <= s and cnt <= 0; otherwise cnt <= cnt+1.
REQ-018 Per channel, with en_i=1 and s == q_filt_o: cnt <= 0.
REQ-019 Latency SHALL be exactly 2+N+1 edges from a d_i change to q_filt_o updating (EnSync=1), given the input is held stable throughout.
REQ-020 An input pulse shorter than N+1 synced cycles SHALL produce no q_filt_o change, no pulse and no event.
REQ-021 The cnt >= debounce_i comparison SHALL be unsigned, so lowering debounce_i mid-count below cnt triggers the update on the next edge; cnt SHALL never wrap.
REQ-022 With en_i=0: cnt SHALL be held at 0, q_filt_o SHALL hold, no pulses SHALL occur, and the synchronizer SHALL keep running.
REQ-023 q_posedge_pulse_o[i] (resp. q_negedge_pulse_o[i]) SHALL be high for exactly one cycle, the first cycle in which q_filt_o[i] shows 1 (resp. 0) after showing the opposite value.
REQ-024 event_o[i] SHALL be set on the edge after a pulse that mode_i[2i+1:2i] qualifies, and cleared on the edge after event_clr_i[i]=1.
REQ-025 When set and clear occur in the same cycle, set SHALL win.
REQ-026 Channels SHALL be fully independent; no cross-channel interaction except through irq_o.

Reset
REQ-027 While rst_i=1 at an edge: sync flops and q_filt_o SHALL load ResetValue, cnt SHALL load 0, event_o SHALL load 0; pulses and irq_o SHALL be 0 in the following cycle.
REQ-028 Reset SHALL produce no edge pulse, even when ResetValue differs from the pre-reset q_filt_o.
REQ-029 Reset asserted mid-count SHALL abort the count; after release, counting SHALL restart from 0.

Verification
REQ-030 Stable input: debounce_i=3, en_i=4'hF, mode=both, d_i[0] 0->1 held -> q_filt_o[0]=1 exactly 6 edges later; q_posedge_pulse_o[0] high 1 cycle; event_o[0]=1 the next edge; irq_o=1.
REQ-031 Glitch: debounce_i=3, d_i[1] high 3 cycles then low -> q_filt_o[1], pulses and event_o[1] remain 0.
REQ-032 Zero threshold: debounce_i=0, d_i[2] 1->0 from a filtered level of 1 -> q_filt_o[2]=0 after 3 edges; q_negedge_pulse_o[2] is 1 cycle; with mode=01 for channel 2, event_o[2] stays 0.
REQ-033 Set/clear collision: event_clr_i[0]=1 in the same cycle a qualified pulse occurs -> event_o[0] stays 1; clear in a later cycle -> event_o[0]=0 and irq_o=0.
REQ-034 Enable and reset mid-count: debounce_i=10, with d_i[3] toggled, drop en_i[3] after 5 cycles -> q_filt_o[3] holds; re-enable -> full 11 cycles required; repeat with rst_i pulsed mid-count instead -> outputs at ResetValue, no pulse.

Source files
------------

// File: rtl/caliptra_prim_debounce_edge_detector.sv
// Per-channel input debouncer with optional 2-flop synchronizer, edge pulses
// on the filtered level, and sticky mode-qualified events feeding one irq.
module caliptra_prim_debounce_edge_detector #(
  parameter int unsigned          Width      = 4,
  parameter int unsigned          CntWidth   = 8,
  parameter logic [Width-1:0]     ResetValue = '0,
  parameter bit                   EnSync     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [Width-1:0]      d_i,
  input  logic [Width-1:0]      en_i,
  input  logic [CntWidth-1:0]   debounce_i,
  input  logic [2*Width-1:0]    mode_i,
  input  logic [Width-1:0]      event_clr_i,
  output logic [Width-1:0]      q_filt_o,
  output logic [Width-1:0]      q_posedge_pulse_o,
  output logic [Width-1:0]      q_negedge_pulse_o,
  output logic [Width-1:0]      event_o,
  output logic                  irq_o
);

  logic [Width-1:0]    s;
  logic [Width-1:0]    q_filt_q, q_filt_d;
  logic [Width-1:0]    q_prev_q, q_prev_d;
  logic [Width-1:0]    event_q, event_d;
  logic [Width-1:0]    rise_sel, fall_sel;
  logic [Width-1:0]    pos_pulse, neg_pulse;
  logic [CntWidth-1:0] cnt_q [Width];
  logic [CntWidth-1:0] cnt_d [Width];

  if (EnSync) begin : g_sync
    logic [Width-1:0] sync1_q, sync1_d;
    logic [Width-1:0] sync2_q, sync2_d;

    always_comb begin
      sync1_d = d_i;
      sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync1_q <= ResetValue;
        sync2_q <= ResetValue;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
      end
    end

    assign s = sync2_q;
  end else begin : g_nosync
    assign s = d_i;
  end

  // Count consecutive enabled cycles where the synced input disagrees with the
  // filtered level; the count is consumed (reset) on the cycle it hits N.
  always_comb begin
    q_filt_d = q_filt_q;
    for (int unsigned i = 0; i < Width; i++) begin
      cnt_d[i] = '0;
      if (en_i[i] && (s[i] != q_filt_q[i])) begin
        if (cnt_q[i] >= debounce_i) begin
          q_filt_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end
      end
    end
  end

  always_comb begin
    q_prev_d = q_filt_q;
    for (int unsigned i = 0; i < Width; i++) begin
      rise_sel[i] = mode_i[2*i];
      fall_sel[i] = mode_i[2*i+1];
    end
    pos_pulse = q_filt_q & ~q_prev_q;
    neg_pulse = ~q_filt_q & q_prev_q;
    // Set has priority over a same-cycle clear.
    event_d   = (event_q & ~event_clr_i) | (pos_pulse & rise_sel) | (neg_pulse & fall_sel);
  end

  // q_prev_q reloads ResetValue alongside q_filt_q so reset itself never pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_filt_q <= ResetValue;
      q_prev_q <= ResetValue;
      event_q  <= '0;
      for (int unsigned i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      q_filt_q <= q_filt_d;
      q_prev_q <= q_prev_d;
      event_q  <= event_d;
      for (int unsigned i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign q_filt_o          = q_filt_q;
  assign q_posedge_pulse_o = pos_pulse;
  assign q_negedge_pulse_o = neg_pulse;
  assign event_o           = event_q;
  assign irq_o             = |event_q;

endmodule

// File: tb/tb_caliptra_prim_debounce_edge_detector.sv
// Directed scenarios plus randomized traffic, checked against a timestamp-based
// reference model of the debounce, pulse and sticky-event rules.
module tb_caliptra_prim_debounce_edge_detector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d, en, clr;
  logic [7:0]   deb;
  logic [7:0]   mode;
  logic [W-1:0] q_filt, q_pos, q_neg, evt;
  logic         irq;

  caliptra_prim_debounce_edge_detector #(
    .Width(4), .CntWidth(8), .ResetValue(4'b0000), .EnSync(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .d_i(d), .en_i(en), .debounce_i(deb),
    .mode_i(mode), .event_clr_i(clr), .q_filt_o(q_filt),
    .q_posedge_pulse_o(q_pos), .q_negedge_pulse_o(q_neg),
    .event_o(evt), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the synced value is d delayed two edges; a channel's
  // filtered level flips once more than N consecutive enabled mismatching
  // edges have elapsed since the last "break" (agreement, disable, flip, reset).
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_q = '0, m_prev = '0, m_evt = '0;
  int           brk [W];
  int           cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] pos, neg, qual, nq;
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_q = '0; m_prev = '0; m_evt = '0;
      for (int i = 0; i < W; i++) brk[i] = cyc;
      return;
    end
    pos  = m_q & ~m_prev;
    neg  = ~m_q & m_prev;
    qual = '0;
    for (int i = 0; i < W; i++) begin
      case (mode[2*i +: 2])
        2'b01:   qual[i] = pos[i];
        2'b10:   qual[i] = neg[i];
        2'b11:   qual[i] = pos[i] | neg[i];
        default: qual[i] = 1'b0;
      endcase
    end
    nq = m_q;
    for (int i = 0; i < W; i++) begin
      if (en[i] && (m_s2[i] != m_q[i])) begin
        if (cyc - brk[i] - 1 >= int'(deb)) begin
          nq[i]  = m_s2[i];
          brk[i] = cyc;
        end
      end else begin
        brk[i] = cyc;
      end
    end
    m_evt  = (m_evt & ~clr) | qual;
    m_prev = m_q;
    m_q    = nq;
    m_s2   = m_s1;
    m_s1   = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("q_filt", 32'(q_filt), 32'(m_q));
    chk("posedge_pulse", 32'(q_pos), 32'(m_q & ~m_prev));
    chk("negedge_pulse", 32'(q_neg), 32'(~m_q & m_prev));
    chk("event", 32'(evt), 32'(m_evt));
    chk("irq", 32'(irq), 32'(|m_evt));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < W; i++) brk[i] = 0;
    rst = 1'b1; d = '0; en = '0; clr = '0; deb = 8'd3; mode = 8'hDF;
    steps(2);
    chk("reset_outputs", {q_filt, q_pos, q_neg, evt, 3'b0, irq}, 32'd0);

    // Stable rise on ch0: update exactly 6 edges after the change.
    rst = 1'b0; en = 4'hF;
    steps(3);
    d[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("rise_latency_ch0", 32'(q_filt[0]), (k == 6) ? 32'd1 : 32'd0);
    end
    chk("rise_pulse_ch0", 32'(q_pos[0]), 32'd1);
    step();
    chk("rise_pulse_one_cycle", 32'(q_pos[0]), 32'd0);
    chk("rise_event_ch0", 32'(evt[0]), 32'd1);
    chk("rise_irq", 32'(irq), 32'd1);

    // Fall on ch0 with clear in the same cycle as the pulse: set wins.
    d[0] = 1'b0;
    steps(6);
    chk("fall_pulse_ch0", 32'(q_neg[0]), 32'd1);
    clr[0] = 1'b1;
    step();
    chk("collision_set_wins", 32'(evt[0]), 32'd1);
    step();
    clr[0] = 1'b0;
    chk("clear_event_ch0", 32'(evt[0]), 32'd0);
    chk("clear_irq", 32'(irq), 32'd0);

    // Glitch on ch1 of 3 cycles with N=3: filtered away.
    d[1] = 1'b1;
    steps(3);
    d[1] = 1'b0;
    steps(10);
    chk("glitch_q_ch1", 32'(q_filt[1]), 32'd0);
    chk("glitch_event_ch1", 32'(evt[1]), 32'd0);

    // Zero threshold on ch2 (mode rise-only): fall takes 3 edges, no event.
    deb = 8'd0;
    d[2] = 1'b1;
    steps(4);
    clr[2] = 1'b1;
    steps(2);
    clr[2] = 1'b0;
    d[2] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("zero_thr_latency_ch2", 32'(q_filt[2]), (k == 3) ? 32'd1 - 32'd1 : 32'd1);
    end
    chk("zero_thr_negpulse_ch2", 32'(q_neg[2]), 32'd1);
    step();
    chk("zero_thr_negpulse_one_cycle", 32'(q_neg[2]), 32'd0);
    chk("zero_thr_no_event_ch2", 32'(evt[2]), 32'd0);

    // Enable dropped mid-count on ch3, then a full 11 cycles after re-enable.
    deb = 8'd10;
    d[3] = 1'b1;
    steps(7);
    en[3] = 1'b0;
    steps(5);
    chk("disable_hold_ch3", 32'(q_filt[3]), 32'd0);
    en[3] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("reenable_latency_ch3", 32'(q_filt[3]), (k == 11) ? 32'd1 : 32'd0);
    end
    steps(2);

    // Reset mid-count: counting restarts from zero, no pulse from reset.
    d[3] = 1'b0;
    steps(7);
    rst = 1'b1;
    step();
    chk("midcount_reset_q", 32'(q_filt), 32'd0);
    chk("midcount_reset_pulses", 32'({q_pos, q_neg}), 32'd0);
    rst = 1'b0;
    d[3] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("post_reset_latency_ch3", 32'(q_filt[3]), (k == 13) ? 32'd1 : 32'd0);
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
        en[i]  = ($urandom_range(0, 9) != 0);
        clr[i] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 39) == 0) deb  = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) mode = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
